// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE result collector.
// Bank FSM states, per-bank control bundle and element-format helpers.
package redmule_pkg;

    typedef enum logic [2:0] {
        FP32,
        FP64,
        FP16,
        FP8,
        FP16ALT
    } fp_format_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:          return 32;
            FP64:          return 64;
            FP16, FP16ALT: return 16;
            FP8:           return 8;
            default:       return 16;
        endcase
    endfunction

    localparam int unsigned CTRL_W = 8;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } z_bank_state_e;

    typedef struct packed {
        logic [CTRL_W-1:0] rows;
        logic [CTRL_W-1:0] cols;
        z_bank_state_e     state;
    } z_collector_ctrl_t;

endpackage

// File: rtl/redmule_z_bank.sv
// One W x H result tile: row-wide write at a capture index,
// column-wide read at a beat index. Storage is never reset.
module redmule_z_bank #(
    parameter int unsigned BITW   = 16,
    parameter int unsigned Height = 4,
    parameter int unsigned Width  = 8,
    localparam int unsigned HW = (Height > 1) ? $clog2(Height) : 1,
    localparam int unsigned WW = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [HW-1:0]           row_idx,
    input  logic [Width*BITW-1:0]   row_data,
    input  logic [WW-1:0]           col_idx,
    output logic [Height*BITW-1:0]  col_data
);

    logic [BITW-1:0] mem [Width][Height];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int w = 0; w < int'(Width); w++) begin
                mem[w][row_idx] <= row_data[w*BITW +: BITW];
            end
        end
    end

    always_comb begin
        col_data = '0;
        for (int h = 0; h < int'(Height); h++) begin
            col_data[h*BITW +: BITW] = mem[col_idx][h];
        end
    end

endmodule

// File: rtl/redmule_z_collector.sv
// Ping-pong result collector: captures W-wide rows into a tile and
// drains the transposed tile as H-wide column beats.
module redmule_z_collector
    import redmule_pkg::*;
#(
    parameter fp_format_e  FpFormat = FP16,
    parameter int unsigned Height   = 4,
    parameter int unsigned Width    = 8,
    localparam int unsigned BITW = fp_width(FpFormat)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic [$clog2(Height+1)-1:0]   tile_rows_i,
    input  logic [$clog2(Width+1)-1:0]    tile_cols_i,
    input  logic [Width*BITW-1:0]         z_result_i,
    input  logic                          z_valid_i,
    output logic                          z_stall_o,
    output logic                          overflow_o,
    output logic [Height*BITW-1:0]        z_o,
    output logic                          z_valid_o,
    input  logic                          z_ready_i,
    output logic                          z_last_o
);

    localparam int unsigned HW = (Height > 1) ? $clog2(Height) : 1;
    localparam int unsigned WW = (Width > 1) ? $clog2(Width) : 1;

    logic              wr_bank;
    logic              rd_bank;
    logic [HW-1:0]     wr_cnt;
    logic [WW-1:0]     rd_cnt;
    z_collector_ctrl_t ctrl [2];
    logic [Height*BITW-1:0] col_data [2];

    logic [CTRL_W-1:0] rows_in;
    logic [CTRL_W-1:0] cols_in;
    logic [CTRL_W-1:0] cur_rows;
    logic              wr_busy;
    logic              capture;
    logic              last_cap;
    logic              rd_active;
    logic              fire;

    assign rows_in = (tile_rows_i == '0) ? CTRL_W'(Height)
                                         : CTRL_W'(tile_rows_i);
    assign cols_in = (tile_cols_i == '0) ? CTRL_W'(Width)
                                         : CTRL_W'(tile_cols_i);

    // First capture of a tile has not latched rows yet; use the live value.
    assign cur_rows = (wr_cnt == '0) ? rows_in : ctrl[wr_bank].rows;

    assign wr_busy   = ctrl[wr_bank].state inside {FULL, DRAINING};
    assign capture   = z_valid_i && !wr_busy;
    assign last_cap  = capture
                    && (CTRL_W'(wr_cnt) == cur_rows - CTRL_W'(1));
    assign rd_active = ctrl[rd_bank].state inside {FULL, DRAINING};
    assign fire      = rd_active && z_ready_i;

    assign z_stall_o = wr_busy;
    assign z_valid_o = rd_active;
    assign z_last_o  = rd_active
                    && (CTRL_W'(rd_cnt) == ctrl[rd_bank].cols - CTRL_W'(1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        redmule_z_bank #(
            .BITW   (BITW),
            .Height (Height),
            .Width  (Width)
        ) u_bank (
            .clk      (clk_i),
            .we       (capture && !clear_i && (wr_bank == 1'(b))),
            .row_idx  (wr_cnt),
            .row_data (z_result_i),
            .col_idx  (rd_cnt),
            .col_data (col_data[b])
        );
    end

    always_comb begin
        z_o = '0;
        for (int h = 0; h < int'(Height); h++) begin
            if (rd_active && (CTRL_W'(h) < ctrl[rd_bank].rows)) begin
                z_o[h*BITW +: BITW] = col_data[rd_bank][h*BITW +: BITW];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            overflow_o <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                ctrl[b] <= '{rows: '0, cols: '0, state: EMPTY};
            end
        end else if (clear_i) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            overflow_o <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                ctrl[b] <= '{rows: '0, cols: '0, state: EMPTY};
            end
        end else begin
            if (z_valid_i && wr_busy) begin
                overflow_o <= 1'b1;
            end
            if (capture) begin
                if (wr_cnt == '0) begin
                    ctrl[wr_bank].rows  <= rows_in;
                    ctrl[wr_bank].cols  <= cols_in;
                    ctrl[wr_bank].state <= FILLING;
                end
                if (last_cap) begin
                    ctrl[wr_bank].state <= FULL;
                    wr_bank             <= ~wr_bank;
                    wr_cnt              <= '0;
                end else begin
                    wr_cnt <= wr_cnt + HW'(1);
                end
            end
            // Capture and drain never target the same bank in one cycle.
            if (fire) begin
                if (z_last_o) begin
                    ctrl[rd_bank].state <= EMPTY;
                    rd_bank             <= ~rd_bank;
                    rd_cnt              <= '0;
                end else begin
                    ctrl[rd_bank].state <= DRAINING;
                    rd_cnt              <= rd_cnt + WW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_redmule_z_collector.sv
// Self-checking bench for redmule_z_collector with a beat-queue
// reference model of captured tiles and their transposed drain.
module tb_redmule_z_collector;
    import redmule_pkg::*;

    localparam int H = 4;
    localparam int W = 8;
    localparam int B = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic [2:0]     rows;
    logic [3:0]     cols;
    logic [W*B-1:0] zr;
    logic           zv;
    logic           stall;
    logic           ovf;
    logic [H*B-1:0] zo;
    logic           zvo;
    logic           rdy;
    logic           zlast;

    always #5 clk = ~clk;

    redmule_z_collector #(
        .FpFormat (FP16),
        .Height   (H),
        .Width    (W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .tile_rows_i (rows),
        .tile_cols_i (cols),
        .z_result_i  (zr),
        .z_valid_i   (zv),
        .z_stall_o   (stall),
        .overflow_o  (ovf),
        .z_o         (zo),
        .z_valid_o   (zvo),
        .z_ready_i   (rdy),
        .z_last_o    (zlast)
    );

    typedef struct packed {
        logic           l;
        logic [H*B-1:0] d;
    } beat_t;

    int errors = 0;
    int checks = 0;

    beat_t          exp_q[$];
    logic [W*B-1:0] m_vec [H];
    int             m_cnt  = 0;
    int             m_rows = H;
    int             m_cols = W;

    logic           hs;
    logic           pend;
    logic           q_err;
    logic [H*B-1:0] obs_z;
    logic [H*B-1:0] exp_z;
    logic           obs_last;
    logic           exp_last;

    function automatic logic [W*B-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Sample the pre-edge view, advance the model, then clock once.
    task automatic tick();
        beat_t bt;
        #1;
        hs       = zvo && rdy && !clear;
        pend     = zvo && !rdy;
        obs_z    = zo;
        obs_last = zlast;
        q_err    = 1'b0;
        if (hs) begin
            if (exp_q.size() == 0) begin
                q_err    = 1'b1;
                exp_z    = ~obs_z;
                exp_last = ~obs_last;
            end else begin
                bt       = exp_q.pop_front();
                exp_z    = bt.d;
                exp_last = bt.l;
            end
        end
        if (zv && !stall && !clear) begin
            if (m_cnt == 0) begin
                m_rows = (rows == 0) ? H : int'(rows);
                m_cols = (cols == 0) ? W : int'(cols);
            end
            m_vec[m_cnt] = zr;
            if (m_cnt == m_rows - 1) begin
                for (int c = 0; c < m_cols; c++) begin
                    bt.d = '0;
                    for (int h = 0; h < m_rows; h++) begin
                        bt.d[h*B +: B] = m_vec[h][c*B +: B];
                    end
                    bt.l = (c == m_cols - 1);
                    exp_q.push_back(bt);
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (clear) begin
            exp_q.delete();
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_two_tiles_and_overflow();
        rows = '0;
        cols = '0;
        rdy  = 1'b0;
        for (int k = 0; k < 2 * H; k++) begin
            zv = 1'b1;
            zr = rand_vec();
            tick();
        end
        zr = rand_vec();
        tick();
        zv = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        clear = 1'b0;
        rows  = '0;
        cols  = '0;
        zr    = '0;
        zv    = 1'b0;
        rdy   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: got %b want 0", ovf);
        end
        checks++;
        if (zvo !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", zvo);
        end
        checks++;
        if (zo !== '0) begin
            errors++;
            $display("FAIL reset_z: got %h want 0", zo);
        end
        checks++;
        if (zlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_last: got %b want 0", zlast);
        end
    endtask

    task automatic test_full_tile();
        logic [H*B-1:0] e;
        rows = '0;
        cols = '0;
        rdy  = 1'b1;
        for (int h = 0; h < H; h++) begin
            zv = 1'b1;
            for (int w = 0; w < W; w++) zr[w*B +: B] = 16'(16 * h + w);
            tick();
            checks++;
            if (zvo !== (h == H - 1)) begin
                errors++;
                $display("FAIL full_valid_rise cap%0d: got %b want %b",
                         h, zvo, (h == H - 1));
            end
        end
        zv = 1'b0;
        for (int c = 0; c < W; c++) begin
            tick();
            e = {16'(48 + c), 16'(32 + c), 16'(16 + c), 16'(c)};
            checks++;
            if (!hs || obs_z !== e || obs_last !== (c == W - 1)) begin
                errors++;
                $display("FAIL full_beat%0d: hs=%b z=%h last=%b want z=%h last=%b",
                         c, hs, obs_z, obs_last, e, (c == W - 1));
            end
        end
        checks++;
        if (zvo !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_end: valid=%b left=%0d want 0/0", zvo, exp_q.size());
        end
    endtask

    task automatic test_ping_pong();
        int beats;
        rows = '0;
        cols = '0;
        rdy  = 1'b0;
        for (int k = 0; k < 2 * H; k++) begin
            zv = 1'b1;
            zr = rand_vec();
            tick();
            checks++;
            if (stall !== (k == 2 * H - 1)) begin
                errors++;
                $display("FAIL pp_stall cap%0d: got %b want %b",
                         k, stall, (k == 2 * H - 1));
            end
        end
        zr = rand_vec();
        tick();
        zv = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL pp_overflow: got %b want 1", ovf);
        end
        rdy   = 1'b1;
        beats = 0;
        for (int t = 0; t < 40 && beats < 2 * W; t++) begin
            tick();
            if (hs) begin
                beats++;
                checks++;
                if (q_err || obs_z !== exp_z || obs_last !== exp_last) begin
                    errors++;
                    $display("FAIL pp_beat%0d: z=%h last=%b want z=%h last=%b",
                             beats, obs_z, obs_last, exp_z, exp_last);
                end
                if (beats == W) begin
                    checks++;
                    if (stall !== 1'b0) begin
                        errors++;
                        $display("FAIL pp_unstall: got %b want 0", stall);
                    end
                end
            end
        end
        checks++;
        if (beats != 2 * W || exp_q.size() != 0) begin
            errors++;
            $display("FAIL pp_count: got %0d beats want %0d", beats, 2 * W);
        end
    endtask

    task automatic test_leftover();
        int beats;
        rows = 3'd2;
        cols = 4'd3;
        rdy  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            zv = 1'b1;
            zr = rand_vec();
            tick();
        end
        zv    = 1'b0;
        beats = 0;
        for (int t = 0; t < 20 && beats < 3; t++) begin
            tick();
            if (hs) begin
                beats++;
                checks++;
                if (q_err || obs_z !== exp_z || obs_last !== exp_last ||
                    obs_z[H*B-1:2*B] !== '0 || obs_last !== (beats == 3)) begin
                    errors++;
                    $display("FAIL left_beat%0d: z=%h last=%b want z=%h last=%b",
                             beats, obs_z, obs_last, exp_z, exp_last);
                end
            end
        end
        checks++;
        if (beats != 3 || zvo !== 1'b0) begin
            errors++;
            $display("FAIL left_count: got %0d beats valid=%b want 3/0", beats, zvo);
        end
    endtask

    task automatic test_backpressure();
        logic [H*B-1:0] pz;
        logic           pl;
        logic           pp;
        pp = 1'b0;
        pz = '0;
        pl = 1'b0;
        for (int t = 0; t < 400; t++) begin
            zv   = 1'($urandom_range(0, 1));
            zr   = rand_vec();
            rows = 3'($urandom_range(0, H));
            cols = 4'($urandom_range(0, W));
            rdy  = ($urandom_range(0, 2) != 0);
            if (pp) begin
                checks++;
                if (zvo !== 1'b1 || zo !== pz || zlast !== pl) begin
                    errors++;
                    $display("FAIL bp_stable t%0d: v=%b z=%h l=%b want 1 %h %b",
                             t, zvo, zo, zlast, pz, pl);
                end
            end
            tick();
            pp = pend;
            pz = obs_z;
            pl = obs_last;
            if (hs) begin
                checks++;
                if (q_err || obs_z !== exp_z || obs_last !== exp_last) begin
                    errors++;
                    $display("FAIL bp_beat t%0d: z=%h last=%b want z=%h last=%b",
                             t, obs_z, obs_last, exp_z, exp_last);
                end
            end
        end
        rdy = 1'b1;
        for (int t = 0; t < 200 && (m_cnt != 0 || exp_q.size() != 0 || zvo); t++) begin
            zv = (m_cnt != 0);
            zr = rand_vec();
            tick();
            if (hs) begin
                checks++;
                if (q_err || obs_z !== exp_z || obs_last !== exp_last) begin
                    errors++;
                    $display("FAIL bp_flush: z=%h last=%b want z=%h last=%b",
                             obs_z, obs_last, exp_z, exp_last);
                end
            end
        end
        zv = 1'b0;
        checks++;
        if (exp_q.size() != 0 || zvo !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: left=%0d valid=%b want 0/0", exp_q.size(), zvo);
        end
    endtask

    task automatic test_clear_reset();
        int beats;
        for (int pass = 0; pass < 2; pass++) begin
            fill_two_tiles_and_overflow();
            rdy   = 1'b1;
            beats = 0;
            for (int t = 0; t < 10 && beats < 2; t++) begin
                tick();
                if (hs) begin
                    beats++;
                    checks++;
                    if (q_err || obs_z !== exp_z || obs_last !== exp_last) begin
                        errors++;
                        $display("FAIL clr_pre_beat%0d: z=%h want %h", beats, obs_z, exp_z);
                    end
                end
            end
            if (pass == 0) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
            end else begin
                #3 rst = 1'b1;
                #2 rst = 1'b0;
                #1;
                exp_q.delete();
                m_cnt = 0;
            end
            checks++;
            if (zvo !== 1'b0 || stall !== 1'b0 || ovf !== 1'b0 || zo !== '0) begin
                errors++;
                $display("FAIL clr_state pass%0d: v=%b stall=%b ovf=%b z=%h want all 0",
                         pass, zvo, stall, ovf, zo);
            end
            rows = '0;
            cols = '0;
            for (int k = 0; k < H; k++) begin
                zv = 1'b1;
                zr = rand_vec();
                tick();
            end
            zv    = 1'b0;
            beats = 0;
            for (int t = 0; t < 20 && beats < W; t++) begin
                tick();
                if (hs) begin
                    beats++;
                    checks++;
                    if (q_err || obs_z !== exp_z || obs_last !== exp_last) begin
                        errors++;
                        $display("FAIL clr_post_beat%0d: z=%h last=%b want z=%h last=%b",
                                 beats, obs_z, obs_last, exp_z, exp_last);
                    end
                end
            end
            checks++;
            if (beats != W || zvo !== 1'b0) begin
                errors++;
                $display("FAIL clr_post_count pass%0d: got %0d want %0d", pass, beats, W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_ping_pong();
        test_leftover();
        test_backpressure();
        test_clear_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
